// File: rtl/cache_pkg.sv
// Shared definitions for the dcache write buffer: write types, entry layout and
// the AXI drain FSM state encoding.
package cache_pkg;

  localparam logic [2:0] WR_TYPE_WORD = 3'b010;
  localparam logic [2:0] WR_TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wbuf_state_e;

  typedef struct packed {
    logic [2:0]   typ;
    logic [31:0]  addr;
    logic [3:0]   wstrb;
    logic [127:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Entry storage for the write buffer: circular array with read/write pointers,
// occupancy count and a per-slot valid mask for address hazard checks.
module wbuf_fifo
  import cache_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           push_i,
  input  wbuf_entry_t                    entry_i,
  input  logic                           pop_i,
  output wbuf_entry_t                    head_o,
  output logic [$clog2(DEPTH):0]         count_o,
  output wbuf_entry_t [DEPTH-1:0]        ents_o,
  output logic [DEPTH-1:0]               valid_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]            wr_ptr_q;
  logic [PW-1:0]            rd_ptr_q;
  logic [CW-1:0]            count_q;
  wbuf_entry_t [DEPTH-1:0]  mem_q;
  logic [PW-1:0]            off_s;

  // Storage needs no reset: a slot is only observed while the count covers it.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A slot is live when its distance from the head is below the count.
  always_comb begin
    off_s   = '0;
    valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_s      = PW'(i) - rd_ptr_q;
      valid_o[i] = ({1'b0, off_s} < count_q);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign ents_o  = mem_q;

endmodule

// File: rtl/cache_wr_buffer.sv
// Dcache write buffer draining line/word writes to AXI, one transaction at a time.
// Optional macro WBUF_HAZARD_CHK_EN enables a precise line-address hazard check.
module cache_wr_buffer
  import cache_pkg::*;
#(
  parameter int         DEPTH = 2,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  input  logic [31:0]  chk_addr,
  output logic         chk_hit,
  output logic         empty,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic         bvalid,
  output logic         bready
);

  localparam int CW = $clog2(DEPTH) + 1;

  wbuf_state_e             state_q;
  logic                    awvalid_q, wvalid_q, wlast_q, bready_q;
  logic [31:0]             awaddr_q, wdata_q;
  logic [7:0]              awlen_q;
  logic [3:0]              wstrb_q;
  logic [127:0]            data_q;
  logic [1:0]              beat_q;
  logic [1:0]              beat_nx_s;
  logic                    push_s, pop_s, line_s;
  logic [CW-1:0]           count_s;
  wbuf_entry_t             head_s;
  wbuf_entry_t             entry_s;
  wbuf_entry_t [DEPTH-1:0] ents_s;
  logic [DEPTH-1:0]        valid_s;
  logic                    unused_s;

  assign wr_rdy    = (count_s < CW'(DEPTH));
  assign push_s    = wr_req && wr_rdy;
  assign pop_s     = (state_q == ST_B) && bvalid;
  assign entry_s   = '{typ: wr_type, addr: wr_addr, wstrb: wr_wstrb, data: wr_data};
  assign line_s    = (head_s.typ == WR_TYPE_LINE);
  assign beat_nx_s = beat_q + 2'd1;

  wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .push_i  (push_s),
    .entry_i (entry_s),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .count_o (count_s),
    .ents_o  (ents_s),
    .valid_o (valid_s)
  );

  // AXI drain FSM; the head stays in the FIFO until its response arrives.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= 32'd0;
      awlen_q   <= 8'd0;
      wstrb_q   <= 4'd0;
      wdata_q   <= 32'd0;
      data_q    <= 128'd0;
      beat_q    <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (count_s != '0) begin
            awaddr_q  <= line_s ? {head_s.addr[31:4], 4'b0000} : head_s.addr;
            awlen_q   <= line_s ? 8'd3 : 8'd0;
            wstrb_q   <= line_s ? 4'hF : head_s.wstrb;
            data_q    <= head_s.data;
            awvalid_q <= 1'b1;
            state_q   <= ST_AW;
          end
        end
        ST_AW: begin
          if (awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wdata_q   <= data_q[31:0];
            wlast_q   <= (awlen_q == 8'd0);
            beat_q    <= 2'd0;
            state_q   <= ST_W;
          end
        end
        ST_W: begin
          if (wready) begin
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= ST_B;
            end else begin
              beat_q  <= beat_nx_s;
              wdata_q <= data_q[32*beat_nx_s +: 32];
              wlast_q <= ({6'd0, beat_nx_s} == awlen_q);
            end
          end
        end
        ST_B: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign empty   = (count_s == '0) && (state_q == ST_IDLE);
  assign awid    = WR_ID;
  assign awaddr  = awaddr_q;
  assign awlen   = awlen_q;
  assign awsize  = 3'd2;
  assign awburst = 2'b01;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = wlast_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

`ifdef WBUF_HAZARD_CHK_EN
  // Line-granular match against every live entry, including the in-flight head.
  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_s[i] && (ents_s[i].addr[31:4] == chk_addr[31:4])) begin
        chk_hit = 1'b1;
      end else begin
        chk_hit = chk_hit;
      end
    end
  end
`else
  assign chk_hit = !empty;
`endif

  assign unused_s = ^{bid, chk_addr, ents_s, valid_s};

endmodule
